payoff_accum: RTL and testbench
===============================

Name: payoff_accum

Overview:
- Downstream consumer of the path generator in the Monte Carlo option-pricing datapath.
- Takes the per-day simulated price stream (one beat per day, DAYS beats per path).
- Computes the European call payoff max(S_T - K, 0) on each path's final day and accumulates it over 2^PATHS_LOG2 paths.
- Emits the mean payoff (undiscounted option price) plus an in-the-money path count.

Parameters:
- DW, 12, width of path price and strike (unsigned integer, output of fp12-to-int stage)
- DAYS_LOG2, 4, log2 of days per path (DAYS = 2^DAYS_LOG2)
- PATHS_LOG2, 8, log2 of paths per pricing run
- ACC_W, DW+PATHS_LOG2, payoff accumulator width (derived; overflow impossible)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a run, samples strike
- strike  in  DW  strike price K
- path_valid  in  1  path beat valid
- path  in  DW  simulated price for current day
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse; price/itm_count valid from this cycle
- price  out  DW  mean payoff, held until next done
- itm_count  out  PATHS_LOG2+1  number of paths with S_T > K, held until next done

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, price=0, itm_count=0; all counters, accumulator and state cleared; state IDLE.
- State IDLE:
  - start=1: latch strike into k_r, clear acc/day_cnt/path_cnt/itm, go RUN.
  - path_valid is ignored.
- State RUN:
  - Each cycle with path_valid=1 is one accepted beat; day_cnt increments, wrapping at DAYS-1 -> 0.
  - Beat with day_cnt == DAYS-1: payoff = (path > k_r) ? path - k_r : 0; acc += payoff; itm += (path > k_r); path_cnt increments.
  - Beat that is the last day of the last path (path_cnt == 2^PATHS_LOG2-1): go FINISH.
  - start is ignored.
  - path_valid=0 stalls; no gaps are required.
- State FINISH (one cycle):
  - price <= acc >> PATHS_LOG2 (truncating); itm_count <= itm.
  - done=1 registered, so it is high the cycle after FINISH is entered, i.e. 2 cycles after the final accepted beat.
  - Go IDLE.
- start in the same cycle as done: accepted (state is IDLE).
- Payoff equality: path == k_r gives payoff 0 and is not counted as ITM.
- itm_count is 1 bit wider than PATHS_LOG2 so a full-ITM run (2^PATHS_LOG2) is representable.
- Reset mid-run: immediate return to IDLE; no done; partial sums discarded; price/itm_count cleared to 0.
- busy=1 in RUN and FINISH, 0 in IDLE.

Optional Feature:
- Macro ASIAN_AVG_EN.
- Defined: arithmetic-average Asian call. Path beats are summed into a DW+DAYS_LOG2 day accumulator; on the last day, avg = (day_sum + path) >> DAYS_LOG2 replaces path in the payoff and ITM compare. The day accumulator clears at each path boundary and on start/reset.
- Undefined: European payoff on final-day price only; no day accumulator is instantiated.

Decomposition:
- Package option_pkg: DW default, state enum (IDLE, RUN, FINISH), payoff function declaration width constants.
- One sub-module payoff_unit: combinational, inputs s and k (DW), outputs payoff (DW) and itm (1).
- The FSM, counters and accumulators stay in payoff_accum.

Test Plan (DAYS_LOG2=2, PATHS_LOG2=2 unless noted):
- European basic: K=100; final-day prices of 4 paths 120, 90, 100, 140 -> done pulse; price=15; itm_count=2.
- Stalls: same stream with path_valid toggling 1/0 each cycle -> identical result. done exactly 2 cycles after the 16th accepted beat.
- All ITM, max values (PATHS_LOG2=2, DW=12): K=0, all beats 4095 -> price=4095; itm_count=4; no overflow.
- Reset mid-run: assert rst after 9 beats -> busy=0, no done, price=0. New run K=50, all beats 60 -> price=10, itm_count=4.
- Ignore rules: path_valid beats in IDLE are ignored; start pulsed during RUN is ignored; start coincident with done starts the next run. Second run K=200, all beats 100 -> price=0, itm_count=0.
- ASIAN_AVG_EN: K=100; each path days 100, 110, 120, 130 (avg 115) -> price=15, itm_count=4. The same stream without the macro gives price=30.

Source files
------------

// File: rtl/option_pkg.sv
// Shared definitions for the option-pricing payoff stage: default widths and
// the run-control state encoding used by payoff_accum.
package option_pkg;

   localparam int DW_DEF         = 12;
   localparam int DAYS_LOG2_DEF  = 4;
   localparam int PATHS_LOG2_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/payoff_unit.sv
// Call payoff evaluation: payoff = max(s - k, 0), itm = (s > k).
// An at-the-money path (s == k) pays nothing and is not counted in the money.
module payoff_unit #(
   parameter int DW = 12
) (
   input  logic [DW-1:0] s,
   input  logic [DW-1:0] k,
   output logic [DW-1:0] payoff,
   output logic          itm
);

   // Strict compare keeps the subtraction non-negative whenever it is used
   always_comb begin
      itm    = (s > k);
      payoff = itm ? (s - k) : '0;
   end

endmodule

// File: rtl/payoff_accum.sv
// Monte Carlo payoff accumulator. Consumes DAYS beats per path, evaluates the
// call payoff at each path's last day, sums over 2^PATHS_LOG2 paths and
// reports the truncated mean plus the in-the-money path count.
// Build option: define ASIAN_AVG_EN to price an arithmetic-average Asian call
// (payoff on the mean of the path's daily prices instead of the final price).
module payoff_accum
   import option_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int DAYS_LOG2  = DAYS_LOG2_DEF,
   parameter int PATHS_LOG2 = PATHS_LOG2_DEF,
   parameter int ACC_W      = DW + PATHS_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DW-1:0]         strike,
   input  logic                  path_valid,
   input  logic [DW-1:0]         path,
   output logic                  busy,
   output logic                  done,
   output logic [DW-1:0]         price,
   output logic [PATHS_LOG2:0]   itm_count
);

   state_t                state_q, state_d;
   logic [DW-1:0]         k_q;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [DAYS_LOG2-1:0]  day_cnt_q;
   logic [PATHS_LOG2-1:0] path_cnt_q;
   logic [PATHS_LOG2:0]   itm_q, itm_d;
   logic [DW-1:0]         price_q;
   logic [PATHS_LOG2:0]   itm_count_q;
   logic                  done_q;

   logic                  beat;
   logic                  last_day;
   logic                  last_path;
   logic [DW-1:0]         s_eval;
   logic [DW-1:0]         pay;
   logic                  pay_itm;

   assign beat      = (state_q == RUN) && path_valid;
   assign last_day  = &day_cnt_q;
   assign last_path = &path_cnt_q;

`ifdef ASIAN_AVG_EN
   logic [DW+DAYS_LOG2-1:0] day_sum_q;
   logic [DW+DAYS_LOG2-1:0] day_total;

   // Running total including the current beat; its mean drives the payoff
   assign day_total = day_sum_q + {{DAYS_LOG2{1'b0}}, path};
   assign s_eval    = DW'(day_total >> DAYS_LOG2);

   // Per-path day accumulator, cleared at each path boundary and on start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         day_sum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         day_sum_q <= '0;
      end else if (beat) begin
         day_sum_q <= last_day ? '0 : day_total;
      end
   end
`else
   assign s_eval = path;
`endif

   payoff_unit #(.DW(DW)) u_payoff (
      .s      (s_eval),
      .k      (k_q),
      .payoff (pay),
      .itm    (pay_itm)
   );

   assign acc_d = acc_q + {{PATHS_LOG2{1'b0}}, pay};
   assign itm_d = itm_q + {{PATHS_LOG2{1'b0}}, pay_itm};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: start only honoured in IDLE, FINISH lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (beat && last_day && last_path) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy = (state_q != IDLE);
   end

   // Counters, accumulators and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q         <= '0;
         acc_q       <= '0;
         day_cnt_q   <= '0;
         path_cnt_q  <= '0;
         itm_q       <= '0;
         price_q     <= '0;
         itm_count_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  k_q        <= strike;
                  acc_q      <= '0;
                  day_cnt_q  <= '0;
                  path_cnt_q <= '0;
                  itm_q      <= '0;
               end
            end
            RUN: begin
               if (beat) begin
                  day_cnt_q <= day_cnt_q + 1'b1;
                  if (last_day) begin
                     acc_q      <= acc_d;
                     itm_q      <= itm_d;
                     path_cnt_q <= path_cnt_q + 1'b1;
                  end
               end
            end
            FINISH: begin
               price_q     <= DW'(acc_q >> PATHS_LOG2);
               itm_count_q <= itm_q;
               done_q      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done      = done_q;
   assign price     = price_q;
   assign itm_count = itm_count_q;

endmodule

// File: tb/tb_payoff_accum.sv
// Directed bench for payoff_accum with DAYS_LOG2=2, PATHS_LOG2=2 (16 beats per run).
module tb_payoff_accum;

   localparam int DW = 12;
   localparam int DL = 2;
   localparam int PL = 2;
   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] strike = '0;
   logic          path_valid = 1'b0;
   logic [DW-1:0] path = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] price;
   logic [PL:0]   itm_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_beat_cyc = 0;

   payoff_accum #(.DW(DW), .DAYS_LOG2(DL), .PATHS_LOG2(PL)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .strike     (strike),
      .path_valid (path_valid),
      .path       (path),
      .busy       (busy),
      .done       (done),
      .price      (price),
      .itm_count  (itm_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Optionally pulse start, then feed 16 beats; ign_at injects a start pulse mid-run
   task automatic run_stream(input logic [DW-1:0] k, input logic [DW-1:0] beats [NB],
                             input bit toggle, input bit do_start, input int ign_at);
      if (do_start) begin
         @(negedge clk);
         start  = 1'b1;
         strike = k;
         @(negedge clk);
         start  = 1'b0;
      end
      for (int i = 0; i < NB; i++) begin
         path_valid = 1'b1;
         path       = beats[i];
         if (i == ign_at) begin
            start  = 1'b1;
            strike = '0;
         end
         last_beat_cyc = cyc;
         @(negedge clk);
         start = 1'b0;
         if (toggle && i != NB - 1) begin
            path_valid = 1'b0;
            @(negedge clk);
         end
      end
      path_valid = 1'b0;
   endtask

   task automatic wait_done(output bit seen, output int at_cyc);
      seen   = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen   = 1'b1;
            at_cyc = cyc;
            return;
         end
      end
   endtask

   task automatic fill_finals(input logic [DW-1:0] f0, input logic [DW-1:0] f1,
                              input logic [DW-1:0] f2, input logic [DW-1:0] f3,
                              output logic [DW-1:0] beats [NB]);
      logic [DW-1:0] f [4];
      f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
      for (int p = 0; p < 4; p++)
         for (int d = 0; d < 4; d++)
            beats[p*4+d] = f[p];
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++; if (price !== 12'd0) begin errors++; $display("FAIL reset_price got %0d want 0", price); end
      checks++; if (itm_count !== 3'd0) begin errors++; $display("FAIL reset_itm got %0d want 0", itm_count); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
   endtask

   task automatic test_european();
      logic [DW-1:0] b [NB];
      bit seen; int at;
      fill_finals(12'd120, 12'd90, 12'd100, 12'd140, b);
      run_stream(12'd100, b, 1'b0, 1'b1, -1);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL eu_done got %0b want 1", seen); end
      checks++; if (price !== 12'd15) begin errors++; $display("FAIL eu_price got %0d want 15", price); end
      checks++; if (itm_count !== 3'd2) begin errors++; $display("FAIL eu_itm got %0d want 2", itm_count); end
      checks++; if (at - last_beat_cyc != 2) begin errors++; $display("FAIL eu_latency got %0d want 2", at - last_beat_cyc); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL eu_done_pulse got %0b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL eu_busy_after got %0b want 0", busy); end
   endtask

   task automatic test_stalls();
      logic [DW-1:0] b [NB];
      bit seen; int at;
      fill_finals(12'd120, 12'd90, 12'd100, 12'd140, b);
      run_stream(12'd100, b, 1'b1, 1'b1, -1);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_done got %0b want 1", seen); end
      checks++; if (price !== 12'd15) begin errors++; $display("FAIL stall_price got %0d want 15", price); end
      checks++; if (itm_count !== 3'd2) begin errors++; $display("FAIL stall_itm got %0d want 2", itm_count); end
      checks++; if (at - last_beat_cyc != 2) begin errors++; $display("FAIL stall_latency got %0d want 2", at - last_beat_cyc); end
   endtask

   task automatic test_max();
      logic [DW-1:0] b [NB];
      bit seen; int at;
      fill_finals(12'd4095, 12'd4095, 12'd4095, 12'd4095, b);
      run_stream(12'd0, b, 1'b0, 1'b1, -1);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL max_done got %0b want 1", seen); end
      checks++; if (price !== 12'd4095) begin errors++; $display("FAIL max_price got %0d want 4095", price); end
      checks++; if (itm_count !== 3'd4) begin errors++; $display("FAIL max_itm got %0d want 4", itm_count); end
   endtask

   task automatic test_reset_midrun();
      logic [DW-1:0] b [NB];
      bit seen; int at; bit saw_done;
      @(negedge clk);
      start = 1'b1; strike = 12'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         path_valid = 1'b1; path = 12'd100;
         @(negedge clk);
      end
      path_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      checks++; if (price !== 12'd0) begin errors++; $display("FAIL rstmid_price got %0d want 0", price); end
      checks++; if (itm_count !== 3'd0) begin errors++; $display("FAIL rstmid_itm got %0d want 0", itm_count); end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got %0b want 0", saw_done); end
      fill_finals(12'd60, 12'd60, 12'd60, 12'd60, b);
      run_stream(12'd50, b, 1'b0, 1'b1, -1);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rerun_done got %0b want 1", seen); end
      checks++; if (price !== 12'd10) begin errors++; $display("FAIL rerun_price got %0d want 10", price); end
      checks++; if (itm_count !== 3'd4) begin errors++; $display("FAIL rerun_itm got %0d want 4", itm_count); end
   endtask

   task automatic test_ignore();
      logic [DW-1:0] b [NB];
      bit seen; int at;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         path_valid = 1'b1; path = 12'd4095;
         @(negedge clk);
      end
      path_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy got %0b want 0", busy); end
      fill_finals(12'd120, 12'd90, 12'd100, 12'd140, b);
      run_stream(12'd100, b, 1'b0, 1'b1, 6);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ign_done got %0b want 1", seen); end
      checks++; if (price !== 12'd15) begin errors++; $display("FAIL ign_price got %0d want 15", price); end
      checks++; if (itm_count !== 3'd2) begin errors++; $display("FAIL ign_itm got %0d want 2", itm_count); end
      // Start coincident with done
      start = 1'b1; strike = 12'd200;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_restart_busy got %0b want 1", busy); end
      fill_finals(12'd100, 12'd100, 12'd100, 12'd100, b);
      run_stream(12'd200, b, 1'b0, 1'b0, -1);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL run2_done got %0b want 1", seen); end
      checks++; if (price !== 12'd0) begin errors++; $display("FAIL run2_price got %0d want 0", price); end
      checks++; if (itm_count !== 3'd0) begin errors++; $display("FAIL run2_itm got %0d want 0", itm_count); end
   endtask

   task automatic test_asian();
      logic [DW-1:0] b [NB];
      logic [DW-1:0] exp_price;
      bit seen; int at;
      for (int p = 0; p < 4; p++)
         for (int d = 0; d < 4; d++)
            b[p*4+d] = 12'(100 + 10*d);
`ifdef ASIAN_AVG_EN
      exp_price = 12'd15;
`else
      exp_price = 12'd30;
`endif
      run_stream(12'd100, b, 1'b0, 1'b1, -1);
      wait_done(seen, at);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL avg_done got %0b want 1", seen); end
      checks++; if (price !== exp_price) begin errors++; $display("FAIL avg_price got %0d want %0d", price, exp_price); end
      checks++; if (itm_count !== 3'd4) begin errors++; $display("FAIL avg_itm got %0d want 4", itm_count); end
   endtask

   initial begin
      test_reset();
      test_european();
      test_stalls();
      test_max();
      test_reset_midrun();
      test_ignore();
      test_asian();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
